biss_pos_monitor: RTL and testbench
===================================

BISS_POS_MONITOR -- requirements
Module: biss_pos_monitor

Interface
REQ-001 SHALL: clk  in  1  system clock, ≤100 MHz, single clock domain.
REQ-002 SHALL: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL: position_data  in  32  frame result from the BiSS-C master, right-aligned; 0xFFFFFFFF = CRC fail, 0xFFFFFFFE = error bit.
REQ-004 SHALL: position_data_valid  in  1  one-cycle frame-complete strobe.
REQ-005 SHALL: error  in  1  encoder error bit, active-low; sampled on the strobe.
REQ-006 SHALL: warn  in  1  encoder warning bit, active-low; sampled on the strobe.
REQ-007 SHALL: resolution_bits  in  8  position width N; 0 or >32 treated as 32.
REQ-008 SHALL: timeout_ticks  in  24  maximum clk cycles between strobes; 0 disables.
REQ-009 SHALL: max_consec_fail  in  4  consecutive bad frames that raise a fault; 0 disables.
REQ-010 SHALL: clear_stats  in  1  one-cycle clear of counters and flags.
REQ-011 SHALL: pos_out  out  32  last good position, masked to N bits.
REQ-012 SHALL: pos_valid  out  1  one-cycle pulse on each good-frame update.
REQ-013 SHALL: delta  out  32  signed position change, modulo 2^N, sign-extended.
REQ-014 SHALL: delta_valid  out  1  one-cycle pulse; delta is meaningful only while it is high.
REQ-015 SHALL: crc_fail_cnt, err_frame_cnt  out  16 each  saturating counters.
REQ-016 SHALL: warn_flag, fault, timeout  out  1 each  status flags, active-high.
REQ-017 SHALL: mon_state  out  2  state debug (0 NO_REF, 1 TRACKING, 2 FAULT).

Function
REQ-018 SHALL classify each strobe with this priority:
- data == 0xFFFFFFFF -> CRC fail;
- else data == 0xFFFFFFFE, or error == 0 -> error frame;
- else good frame.
- With N = 32, a real reading of 0xFFFFFFFF counts as a CRC fail.
REQ-019 SHALL register all outputs; every strobe response appears exactly 1 clk after the strobe.
REQ-020 SHALL, on a good frame:
- set pos_out = data & (2^N − 1);
- pulse pos_valid;
- clear the consecutive-fail count.
REQ-021 SHALL compute delta = (new − previous good) mod 2^N, with bit N−1 sign-extended to 32 bits (e.g. N=26, 0x0000001 − 0x3FFFFFF = +2).
REQ-022 SHALL pulse delta_valid only for good frames received in TRACKING; good frames in NO_REF or FAULT reload the reference without delta_valid.
REQ-023 SHALL, on a bad frame:
- hold pos_out;
- keep pos_valid and delta_valid low;
- increment the matching counter, saturating at 0xFFFF;
- increment a 4-bit consecutive-fail count, saturating at 15.
REQ-024 SHALL update warn_flag = ~warn on every strobe, regardless of frame class.
REQ-025 SHALL implement this state machine:
- NO_REF -> TRACKING on a good frame.
- TRACKING -> FAULT when the consecutive-fail count reaches a nonzero max_consec_fail.
- TRACKING -> NO_REF on timeout.
- FAULT -> TRACKING on a good frame (re-reference, no delta_valid).
- Any state -> NO_REF on clear_stats without a coincident good frame.
REQ-026 SHALL assert fault exactly while in FAULT.
REQ-027 SHALL run a watchdog:
- counter cleared on each strobe, otherwise incremented;
- on reaching a nonzero timeout_ticks, set timeout and hold the counter;
- timeout is sticky until the next strobe or clear_stats;
- a timeout in FAULT does not change state.
REQ-028 SHALL handle clear_stats coincident with a strobe as follows:
- counters and consecutive-fail count end at 0; that frame is not counted;
- a coincident good frame still updates pos_out and pos_valid and enters TRACKING, without delta_valid.
REQ-029 SHALL apply a resolution_bits change from the next strobe onward; no state is flushed.

Reset
REQ-030 SHALL, while rst=1, override all other inputs.
REQ-031 SHALL drive these values while rst=1 and in the cycle after:
- pos_out, delta, crc_fail_cnt, err_frame_cnt, watchdog = 0;
- pos_valid, delta_valid, warn_flag, fault, timeout = 0;
- state = NO_REF.
REQ-032 SHALL discard a strobe coincident with rst.

Verification
REQ-033 SHALL verify wrap: N=26, good 0x3FFFFFF then good 0x0000001 -> second delta_valid=1, delta=0x00000002, pos_out=0x0000001.
REQ-034 SHALL verify fault: max_consec_fail=3, TRACKING, three strobes of 0xFFFFFFFF -> crc_fail_cnt=3, fault=1 one clk after the third; next good frame -> fault=0, delta_valid=0.
REQ-035 SHALL verify error classification: strobe with data 0x00001234 and error=0 -> err_frame_cnt+1, pos_out unchanged, pos_valid=0.
REQ-036 SHALL verify timeout: timeout_ticks=100, no strobe for 100 cycles -> timeout=1, state NO_REF; next good frame -> timeout=0, delta_valid=0.
REQ-037 SHALL verify saturation and clear: 65540 CRC-fail strobes -> crc_fail_cnt=0xFFFF; clear_stats coincident with a good frame -> counters 0, pos_valid=1, state TRACKING.
REQ-038 SHALL verify reset mid-stream: rst during TRACKING with a coincident strobe -> all REQ-031 values, no pos_valid.

Source files
------------

// File: rtl/biss_pos_monitor_if.sv
// Frame bus from the BiSS-C master into the position monitor.
//   position_data       : 32-bit frame result, right-aligned (0xFFFFFFFF CRC fail,
//                         0xFFFFFFFE error bit)
//   position_data_valid : one-cycle frame-complete strobe
//   error, warn         : encoder status bits, active-low, valid with the strobe
// master = frame source, slave = monitor.
interface biss_pos_monitor_if;
  logic [31:0] position_data;
  logic        position_data_valid;
  logic        error;
  logic        warn;

  modport master (output position_data, position_data_valid, error, warn);
  modport slave  (input  position_data, position_data_valid, error, warn);
endinterface

// File: rtl/biss_pos_monitor.sv
// BiSS-C position monitor: classifies each frame, tracks the last good position,
// produces a wrapped signed delta, counts bad frames, and runs a frame watchdog.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus               : frame bus (slave side)
//   resolution_bits   : position width N (0 or >32 means 32)
//   timeout_ticks     : max cycles between strobes (0 disables)
//   max_consec_fail   : consecutive bad frames that raise fault (0 disables)
//   clear_stats       : one-cycle clear of counters/flags
//   pos_out/pos_valid : last good position and its update pulse
//   delta/delta_valid : signed change modulo 2^N, sign-extended
//   crc_fail_cnt, err_frame_cnt : saturating counters
//   warn_flag, fault, timeout   : status flags
//   mon_state         : 0 NO_REF, 1 TRACKING, 2 FAULT
module biss_pos_monitor (
  input  logic                     clk,
  input  logic                     rst,
  biss_pos_monitor_if.slave        bus,
  input  logic [7:0]               resolution_bits,
  input  logic [23:0]              timeout_ticks,
  input  logic [3:0]               max_consec_fail,
  input  logic                     clear_stats,
  output logic [31:0]              pos_out,
  output logic                     pos_valid,
  output logic [31:0]              delta,
  output logic                     delta_valid,
  output logic [15:0]              crc_fail_cnt,
  output logic [15:0]              err_frame_cnt,
  output logic                     warn_flag,
  output logic                     fault,
  output logic                     timeout,
  output logic [1:0]               mon_state
);
  typedef enum logic [1:0] {NO_REF = 2'd0, TRACKING = 2'd1, FAULT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  consec;
  logic [23:0] wd;

  logic        strobe, is_crc, is_err, is_good, is_bad, timeout_evt, track_delta;
  logic [5:0]  n_eff;
  logic [31:0] mask, pos_new, diff, delta_new;
  logic [3:0]  consec_inc;

  assign strobe = bus.position_data_valid;

  always_comb begin
    is_crc  = (bus.position_data == 32'hFFFF_FFFF);
    is_err  = !is_crc && ((bus.position_data == 32'hFFFF_FFFE) || !bus.error);
    is_good = strobe && !is_crc && !is_err;
    is_bad  = strobe && (is_crc || is_err);
  end

  // Shifting by 32 yields 0, so N=32 naturally gives an all-ones mask.
  assign n_eff   = (resolution_bits == 8'd0 || resolution_bits > 8'd32) ? 6'd32
                                                                         : resolution_bits[5:0];
  assign mask    = ~(32'hFFFF_FFFF << n_eff);
  assign pos_new = bus.position_data & mask;
  // Difference against the previous good position, wrapped then sign-extended from bit N-1.
  assign diff      = (pos_new - pos_out) & mask;
  assign delta_new = diff[n_eff - 6'd1] ? (diff | ~mask) : diff;

  assign consec_inc  = (consec == 4'hF) ? 4'hF : consec + 4'd1;
  assign track_delta = is_good && (state_q == TRACKING) && !clear_stats;
  // Fires once, on the cycle the idle count reaches the limit.
  assign timeout_evt = !strobe && !clear_stats && !timeout && (timeout_ticks != 24'd0) &&
                       (({1'b0, wd} + 25'd1) >= {1'b0, timeout_ticks});

  always_comb begin
    state_d = state_q;
    if (clear_stats && !is_good)
      state_d = NO_REF;
    else if (is_good)
      state_d = TRACKING;
    else if (state_q == TRACKING) begin
      if (is_bad && (max_consec_fail != 4'd0) && (consec_inc >= max_consec_fail))
        state_d = FAULT;
      else if (timeout_evt)
        state_d = NO_REF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= NO_REF;
      fault         <= 1'b0;
      pos_out       <= '0;
      pos_valid     <= 1'b0;
      delta         <= '0;
      delta_valid   <= 1'b0;
      crc_fail_cnt  <= '0;
      err_frame_cnt <= '0;
      warn_flag     <= 1'b0;
      consec        <= '0;
      wd            <= '0;
      timeout       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fault       <= (state_d == FAULT);
      pos_valid   <= is_good;
      delta_valid <= track_delta;
      if (is_good)     pos_out <= pos_new;
      if (track_delta) delta   <= delta_new;

      if (strobe)           warn_flag <= ~bus.warn;
      else if (clear_stats) warn_flag <= 1'b0;

      if (clear_stats) begin
        crc_fail_cnt  <= '0;
        err_frame_cnt <= '0;
      end else if (is_bad) begin
        if (is_crc && crc_fail_cnt != 16'hFFFF)  crc_fail_cnt  <= crc_fail_cnt + 16'd1;
        if (is_err && err_frame_cnt != 16'hFFFF) err_frame_cnt <= err_frame_cnt + 16'd1;
      end

      if (clear_stats || is_good) consec <= '0;
      else if (is_bad)            consec <= consec_inc;

      if (strobe || clear_stats) begin
        wd      <= '0;
        timeout <= 1'b0;
      end else if (timeout_evt) begin
        wd      <= wd + 24'd1;
        timeout <= 1'b1;
      end else if (!timeout && wd != 24'hFF_FFFF) begin
        wd <= wd + 24'd1;
      end
    end
  end

  assign mon_state = state_q;
endmodule

// File: tb/tb_biss_pos_monitor.sv
module tb_biss_pos_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  resolution_bits;
  logic [23:0] timeout_ticks;
  logic [3:0]  max_consec_fail;
  logic        clear_stats;
  logic [31:0] pos_out, delta;
  logic        pos_valid, delta_valid, warn_flag, fault, timeout;
  logic [15:0] crc_fail_cnt, err_frame_cnt;
  logic [1:0]  mon_state;
  int total = 0;
  int bad   = 0;

  biss_pos_monitor_if bus ();

  biss_pos_monitor dut (
    .clk(clk), .rst(rst), .bus(bus),
    .resolution_bits(resolution_bits), .timeout_ticks(timeout_ticks),
    .max_consec_fail(max_consec_fail), .clear_stats(clear_stats),
    .pos_out(pos_out), .pos_valid(pos_valid), .delta(delta), .delta_valid(delta_valid),
    .crc_fail_cnt(crc_fail_cnt), .err_frame_cnt(err_frame_cnt),
    .warn_flag(warn_flag), .fault(fault), .timeout(timeout), .mon_state(mon_state)
  );

  always #5 clk = ~clk;

  // One-cycle strobe driven at negedge; returns 1ns after the capturing edge.
  task automatic strobe(input logic [31:0] d, input logic err_n, input logic warn_n);
    @(negedge clk);
    bus.position_data = d; bus.error = err_n; bus.warn = warn_n;
    bus.position_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.position_data_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.position_data = '0; bus.position_data_valid = 1'b0; bus.error = 1'b1; bus.warn = 1'b1;
    resolution_bits = 8'd26; timeout_ticks = '0; max_consec_fail = '0; clear_stats = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++; if (pos_out !== 32'h0) begin bad++; $display("FAIL rst_pos got=%h exp=0", pos_out); end
    total++; if ({pos_valid, delta_valid, warn_flag, fault, timeout} !== 5'b0) begin bad++;
      $display("FAIL rst_flags got=%b exp=00000", {pos_valid, delta_valid, warn_flag, fault, timeout}); end
    total++; if ({crc_fail_cnt, err_frame_cnt, mon_state} !== 34'h0) begin bad++;
      $display("FAIL rst_cnt got=%h %h %0d exp=0", crc_fail_cnt, err_frame_cnt, mon_state); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_wrap;
    strobe(32'h03FF_FFFF, 1'b1, 1'b1);
    total++; if ({pos_valid, delta_valid, mon_state} !== 4'b1001 || pos_out !== 32'h03FF_FFFF) begin bad++;
      $display("FAIL wrap_first got=%b pos=%h exp=1001 pos=03ffffff", {pos_valid, delta_valid, mon_state}, pos_out); end
    strobe(32'h0000_0001, 1'b1, 1'b1);
    total++; if (delta_valid !== 1'b1 || delta !== 32'h2 || pos_out !== 32'h1) begin bad++;
      $display("FAIL wrap_fwd got=%b %h %h exp=1 00000002 00000001", delta_valid, delta, pos_out); end
    strobe(32'h0000_0000, 1'b1, 1'b1);
    total++; if (delta_valid !== 1'b1 || delta !== 32'hFFFF_FFFF) begin bad++;
      $display("FAIL wrap_neg got=%b %h exp=1 ffffffff", delta_valid, delta); end
  endtask

  task automatic test_error;
    strobe(32'h0000_1234, 1'b0, 1'b0);
    total++; if (err_frame_cnt !== 16'd1 || pos_out !== 32'h0 || pos_valid !== 1'b0 || delta_valid !== 1'b0) begin bad++;
      $display("FAIL err_bit got=%h %h %b%b exp=1 0 00", err_frame_cnt, pos_out, pos_valid, delta_valid); end
    total++; if (warn_flag !== 1'b1) begin bad++; $display("FAIL warn_set got=%b exp=1", warn_flag); end
    strobe(32'hFFFF_FFFE, 1'b1, 1'b1);
    total++; if (err_frame_cnt !== 16'd2 || crc_fail_cnt !== 16'd0 || warn_flag !== 1'b0) begin bad++;
      $display("FAIL err_code got=%h %h %b exp=2 0 0", err_frame_cnt, crc_fail_cnt, warn_flag); end
  endtask

  task automatic test_fault;
    max_consec_fail = 4'd3;
    strobe(32'h0000_0010, 1'b1, 1'b1);
    total++; if (delta_valid !== 1'b1 || delta !== 32'h10) begin bad++;
      $display("FAIL fault_ref got=%b %h exp=1 00000010", delta_valid, delta); end
    strobe(32'hFFFF_FFFF, 1'b1, 1'b1);
    strobe(32'hFFFF_FFFF, 1'b1, 1'b1);
    total++; if (fault !== 1'b0 || mon_state !== 2'd1) begin bad++;
      $display("FAIL fault_early got=%b %0d exp=0 1", fault, mon_state); end
    strobe(32'hFFFF_FFFF, 1'b1, 1'b1);
    total++; if (crc_fail_cnt !== 16'd3 || fault !== 1'b1 || mon_state !== 2'd2) begin bad++;
      $display("FAIL fault_set got=%h %b %0d exp=3 1 2", crc_fail_cnt, fault, mon_state); end
    strobe(32'h0000_0020, 1'b1, 1'b1);
    total++; if (fault !== 1'b0 || delta_valid !== 1'b0 || pos_valid !== 1'b1 || mon_state !== 2'd1 || pos_out !== 32'h20) begin bad++;
      $display("FAIL fault_exit got=%b%b%b %0d %h exp=001 1 00000020", fault, delta_valid, pos_valid, mon_state, pos_out); end
  endtask

  task automatic test_timeout;
    max_consec_fail = 4'd0;
    timeout_ticks = 24'd100;
    strobe(32'h0000_0030, 1'b1, 1'b1);
    total++; if (delta_valid !== 1'b1 || delta !== 32'h10) begin bad++;
      $display("FAIL to_ref got=%b %h exp=1 00000010", delta_valid, delta); end
    repeat (99) @(posedge clk); #1;
    total++; if (timeout !== 1'b0 || mon_state !== 2'd1) begin bad++;
      $display("FAIL to_early got=%b %0d exp=0 1", timeout, mon_state); end
    @(posedge clk); #1;
    total++; if (timeout !== 1'b1 || mon_state !== 2'd0) begin bad++;
      $display("FAIL to_set got=%b %0d exp=1 0", timeout, mon_state); end
    repeat (5) @(posedge clk); #1;
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timeout); end
    strobe(32'h0000_0040, 1'b1, 1'b1);
    total++; if (timeout !== 1'b0 || delta_valid !== 1'b0 || pos_valid !== 1'b1 || mon_state !== 2'd1) begin bad++;
      $display("FAIL to_exit got=%b%b%b %0d exp=001 1", timeout, delta_valid, pos_valid, mon_state); end
    timeout_ticks = 24'd0;
  endtask

  task automatic test_sat_clear;
    @(negedge clk);
    bus.position_data = 32'hFFFF_FFFF; bus.error = 1'b1; bus.warn = 1'b1;
    bus.position_data_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1 bus.position_data_valid = 1'b0;
    total++; if (crc_fail_cnt !== 16'hFFFF || err_frame_cnt !== 16'd2) begin bad++;
      $display("FAIL sat got=%h %h exp=ffff 0002", crc_fail_cnt, err_frame_cnt); end
    @(negedge clk);
    bus.position_data = 32'h0000_0055; bus.position_data_valid = 1'b1; clear_stats = 1'b1;
    @(posedge clk); #1;
    bus.position_data_valid = 1'b0; clear_stats = 1'b0;
    total++; if (crc_fail_cnt !== 16'h0 || err_frame_cnt !== 16'h0) begin bad++;
      $display("FAIL clr_cnt got=%h %h exp=0 0", crc_fail_cnt, err_frame_cnt); end
    total++; if (pos_valid !== 1'b1 || delta_valid !== 1'b0 || mon_state !== 2'd1 || pos_out !== 32'h55) begin bad++;
      $display("FAIL clr_good got=%b%b %0d %h exp=10 1 00000055", pos_valid, delta_valid, mon_state, pos_out); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rst = 1'b1;
    bus.position_data = 32'h0000_0077; bus.error = 1'b1; bus.warn = 1'b0;
    bus.position_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.position_data_valid = 1'b0;
    total++; if ({pos_out, delta, crc_fail_cnt, err_frame_cnt} !== 96'h0 ||
                 {pos_valid, delta_valid, warn_flag, fault, timeout, mon_state} !== 7'b0) begin bad++;
      $display("FAIL rstmid got=%h %h %b%b%b%b%b %0d exp=0", pos_out, delta,
               pos_valid, delta_valid, warn_flag, fault, timeout, mon_state); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (pos_out !== 32'h0 || pos_valid !== 1'b0 || mon_state !== 2'd0) begin bad++;
      $display("FAIL rstmid_after got=%h %b %0d exp=0 0 0", pos_out, pos_valid, mon_state); end
  endtask

  task automatic test_res32;
    resolution_bits = 8'd0;
    strobe(32'h89AB_CDEF, 1'b1, 1'b1);
    total++; if (pos_out !== 32'h89AB_CDEF || mon_state !== 2'd1) begin bad++;
      $display("FAIL res0 got=%h %0d exp=89abcdef 1", pos_out, mon_state); end
    strobe(32'hFFFF_FFFF, 1'b1, 1'b1);
    total++; if (crc_fail_cnt !== 16'd1 || pos_out !== 32'h89AB_CDEF || pos_valid !== 1'b0) begin bad++;
      $display("FAIL res32_crc got=%h %h %b exp=1 89abcdef 0", crc_fail_cnt, pos_out, pos_valid); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_error();
    test_fault();
    test_timeout();
    test_sat_clear();
    test_reset_mid();
    test_res32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
